// File: rtl/seqdet_gen.sv
// seqdet_gen: serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Define SEQDET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seqdet_gen #(
    parameter int          MAX_LEN = 8,
    parameter int          CNT_W   = 8,
    parameter logic [15:0] DEF_PAT = 16'h0012,
    parameter logic [4:0]  DEF_LEN = 5'd5,
    parameter logic        DEF_OVL = 1'b1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               ain,
    input  logic               ain_vld,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [4:0]         cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               zout,
    output logic [CNT_W-1:0]   match_cnt
);
    localparam int             FW   = $clog2(MAX_LEN);
    localparam logic [4:0]     MAXL = 5'(MAX_LEN);
    localparam logic [FW-1:0]  FMAX = FW'(MAX_LEN - 1);
    logic [MAX_LEN-1:0] pat_r, win, mask;
    logic [MAX_LEN-2:0] hist_r;
    logic [FW-1:0]      fill_r;
    logic [4:0]         len_r, len_new;
    logic               ovl_r, match;
    always_comb begin
        win = {hist_r, ain};
        for (int i = 0; i < MAX_LEN; i++) mask[i] = 5'(i) < len_r;
        match = ain_vld && !cfg_load && (5'(fill_r) + 5'd1 >= len_r) && (((win ^ pat_r) & mask) == '0);
        len_new = cfg_len < 5'd2 ? 5'd2 : cfg_len > MAXL ? MAXL : cfg_len;
    end
    // A load discards the sample on its edge but keeps hist_r; clearing fill_r makes the old bits invisible.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pat_r  <= DEF_PAT[MAX_LEN-1:0];
            len_r  <= DEF_LEN;
            ovl_r  <= DEF_OVL;
            hist_r <= '0;
            fill_r <= '0;
            zout   <= 1'b0;
        end else if (cfg_load) begin
            pat_r  <= cfg_pat;
            len_r  <= len_new;
            ovl_r  <= cfg_ovl;
            fill_r <= '0;
            zout   <= 1'b0;
        end else begin
            zout <= match;
            if (ain_vld) begin
                hist_r <= win[MAX_LEN-2:0];
                fill_r <= (match && !ovl_r) ? '0 : fill_r == FMAX ? fill_r : fill_r + FW'(1);
            end
        end
    end
`ifdef SEQDET_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) match_cnt <= '0;
        else if (cnt_clr) match_cnt <= '0;
        else if (match && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
    end
`else
    logic unused_clr;
    assign unused_clr = cnt_clr;
    assign match_cnt  = '0;
`endif
endmodule

// File: doc/seqdet_gen.md
SEQDET_GEN -- requirements
Module: seqdet_gen

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the longest detectable pattern in bits (legal 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-003 The block SHALL have parameter DEF_PAT, default 16'h0012 (10010), giving the pattern loaded at reset.
REQ-004 The block SHALL have parameter DEF_LEN, default 5, giving the pattern length loaded at reset.
REQ-005 The block SHALL have parameter DEF_OVL, default 1, giving the overlap mode loaded at reset.
REQ-006 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 nrst  input  1  reset, asynchronous and active-low.
REQ-008 ain  input  1  serial data bit.
REQ-009 ain_vld  input  1  qualifies ain; a bit is sampled only on edges where ain_vld=1.
REQ-010 cfg_load  input  1  one-cycle strobe that loads cfg_pat, cfg_len and cfg_ovl.
REQ-011 cfg_pat  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
REQ-012 cfg_len  input  5  pattern length.
REQ-013 cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-014 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-015 zout  output  1  registered one-cycle match pulse.
REQ-016 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-017 The block SHALL keep active registers pat_r, len_r and ovl_r; detection SHALL use only these registers, never the cfg_* inputs directly.
REQ-018 The block SHALL keep hist_r, the last MAX_LEN-1 sampled bits, and fill_r, the number of valid bits in hist_r (saturating at MAX_LEN-1).
REQ-019 Each edge with ain_vld=1 SHALL shift ain into hist_r LSB and increment fill_r (saturating).
REQ-020 A match SHALL occur on an edge where ain_vld=1, fill_r >= len_r-1, and the low len_r bits of {hist_r, ain} equal the low len_r bits of pat_r.
REQ-021 zout SHALL be 1 for exactly the one cycle following a match edge and 0 otherwise; latency from the final pattern bit sample to zout is 1 clock.
REQ-022 With ovl_r=1, fill_r SHALL continue normally after a match, so a pattern suffix may start the next match.
REQ-023 With ovl_r=0, fill_r SHALL be set to 0 on a match edge, so no bit of one match contributes to the next.
REQ-024 Edges with ain_vld=0 SHALL leave hist_r, fill_r and match_cnt unchanged and SHALL drive zout to 0.
REQ-025 On cfg_load=1, pat_r, len_r and ovl_r SHALL be loaded and fill_r and zout cleared; ain on that edge SHALL be discarded even if ain_vld=1.
REQ-026 A cfg_len below 2 SHALL load as 2; a cfg_len above MAX_LEN SHALL load as MAX_LEN.
REQ-027 Pattern bits of pat_r at or above len_r SHALL be ignored.

Reset
REQ-028 While nrst=0, the block SHALL hold pat_r=DEF_PAT, len_r=DEF_LEN, ovl_r=DEF_OVL, hist_r=0, fill_r=0, zout=0 and match_cnt=0.
REQ-029 Assertion of nrst mid-pattern SHALL discard all partial progress; the first post-reset sample SHALL be treated as bit 1 of a new window.

Configuration
REQ-030 With macro SEQDET_CNT_EN defined, match_cnt SHALL increment on every match edge and saturate at all-ones.
REQ-031 With SEQDET_CNT_EN defined, cnt_clr=1 SHALL set match_cnt to 0; cnt_clr SHALL take precedence over a simultaneous match, and that match SHALL not be counted.
REQ-032 With SEQDET_CNT_EN defined, cfg_load SHALL not affect match_cnt.
REQ-033 Without SEQDET_CNT_EN, match_cnt SHALL be constant 0, cnt_clr SHALL be ignored, and no counter flops SHALL be built; all ports SHALL still exist.

Verification
REQ-034 Reset defaults, ain_vld=1, ain=1,0,0,1,0,0,1,0 -> zout pulses after the 5th and 8th bits (overlap).
REQ-035 Load cfg_ovl=0 with default pattern, same stream -> zout pulses after the 5th bit only.
REQ-036 Load cfg_pat=8'b10110111, cfg_len=8, send 10110111 with ain_vld deasserted for 3 cycles mid-stream -> one zout pulse, one cycle after the last valid bit.
REQ-037 Send 1,0,0,1, assert nrst low, release, send 0 -> no zout; then send 1,0,0,1,0 -> zout pulse.
REQ-038 SEQDET_CNT_EN, CNT_W=2, 5 matches -> match_cnt=3; cnt_clr coincident with the 6th match -> match_cnt=0.
REQ-039 cfg_len=1 and cfg_len=20 with MAX_LEN=8 -> len_r reads back as 2 and 8 respectively.
